kahan_merge: RTL and testbench

Streaming Kahan combiner that sits directly downstream of `kahan_start`. Each input beat carries two partial sums with their compensation terms: (sum_a, c_a) and (sum_b, c_b). The block folds every beat into one running (sum, c) pair using four sequential `kahan_step` operations. At the end of a frame, marked by `last_i`, it presents the final pair and the frame's beat count on a valid/ready output.

---
 rtl/kahan_pkg.sv | 20 ++
 rtl/kahan_step.sv | 117 +++++++++++
 rtl/kahan_merge.sv | 117 +++++++++++
 tb/tb_kahan_merge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kahan_pkg.sv
// Shared definitions for the Kahan summation blocks: format width helper,
// controller state encoding and sign negation on raw FP bit patterns.
package kahan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    OUT
  } state_t;

  function automatic int bit_width(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  // Works on any format up to 64 bits; callers zero-extend and truncate.
  function automatic logic [63:0] flip_sign(input logic [63:0] v, input int w);
    return v ^ (64'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/kahan_step.sv
// One Kahan compensated-add step (y = elem - c, t = sum + y, c' = (t - sum) - y)
// on a small IEEE-like format with round-to-nearest-even, pipelined to STEP_LAT_P.
module kahan_step
  import kahan_pkg::*;
#(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT_P   = 2,
  localparam int BIT_WIDTH_I = bit_width(EXP_WIDTH_I, MANT_WIDTH_I)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [BIT_WIDTH_I-1:0] elem_i,
  input  logic [BIT_WIDTH_I-1:0] sum_i,
  input  logic [BIT_WIDTH_I-1:0] c_i,
  output logic [BIT_WIDTH_I-1:0] sum_o,
  output logic [BIT_WIDTH_I-1:0] c_o
);

  localparam int E  = EXP_WIDTH_I;
  localparam int M  = MANT_WIDTH_I;
  localparam int BW = BIT_WIDTH_I;
  localparam int SW = M + 4;

  function automatic logic [BW-1:0] neg(input logic [BW-1:0] v);
    return BW'(flip_sign(64'(v), BW));
  endfunction

  // Operands are ordered by magnitude so the aligned subtraction never goes negative;
  // three extra low bits hold guard, round and sticky for nearest-even rounding.
  function automatic logic [BW-1:0] fp_add(input logic [BW-1:0] x, input logic [BW-1:0] y);
    logic [BW-1:0] a, b, res;
    logic [E-1:0]  ea, eb;
    logic [SW-1:0] sa, sb, sh;
    logic [SW:0]   acc;
    logic          sticky, rnd;
    int            ex, d;
    res = '0; sa = '0; sb = '0; sh = '0; acc = '0; sticky = 1'b0; rnd = 1'b0; ex = 0; d = 0;
    if (x[BW-2:0] >= y[BW-2:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = a[BW-2:M];
    eb = b[BW-2:M];
    if (&ea || &eb) begin
      if ((&ea && |a[M-1:0]) || (&eb && |b[M-1:0]) || (&ea && &eb && a[BW-1] != b[BW-1]))
        res = {1'b0, {E{1'b1}}, {M{1'b1}}};
      else
        res = a;
    end else begin
      sa = {|ea, a[M-1:0], 3'b000};
      sb = {|eb, b[M-1:0], 3'b000};
      ex = (|ea) ? int'(ea) : 1;
      d  = ex - ((|eb) ? int'(eb) : 1);
      if (d >= SW) begin
        sh = '0;
        sticky = |sb;
      end else begin
        sh = sb >> d;
        sticky = |(sb & ~({SW{1'b1}} << d));
      end
      sh[0] = sh[0] | sticky;
      if (a[BW-1] == b[BW-1]) acc = {1'b0, sa} + {1'b0, sh};
      else                    acc = {1'b0, sa} - {1'b0, sh};
      if (acc[SW]) begin
        acc = {1'b0, acc[SW:2], acc[1] | acc[0]};
        ex  = ex + 1;
      end else begin
        for (int i = 0; i < SW; i++) begin
          if (!acc[SW-1] && ex > 1) begin
            acc = acc << 1;
            ex  = ex - 1;
          end
        end
      end
      rnd = acc[2] & (acc[1] | acc[0] | acc[3]);
      acc = (SW+1)'(acc[SW-1:3]) + (SW+1)'(rnd);
      if (acc[M+1]) begin
        acc = acc >> 1;
        ex  = ex + 1;
      end
      if (ex >= (1 << E) - 1)
        res = {a[BW-1], {E{1'b1}}, {M{1'b0}}};
      else if (acc == '0)
        res = {a[BW-1] & b[BW-1], {(BW-1){1'b0}}};
      else
        res = {a[BW-1], (acc[M] ? E'(ex) : {E{1'b0}}), acc[M-1:0]};
    end
    return res;
  endfunction

  logic [BW-1:0] y, t, c_new;

  always_comb begin
    y     = fp_add(elem_i, neg(c_i));
    t     = fp_add(sum_i, y);
    c_new = fp_add(fp_add(t, neg(sum_i)), neg(y));
  end

  if (STEP_LAT_P <= 1) begin : g_comb
    assign sum_o = t;
    assign c_o   = c_new;
  end else begin : g_pipe
    logic [STEP_LAT_P-2:0][2*BW-1:0] pipe;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe <= '0;
      end else begin
        pipe[0] <= {t, c_new};
        for (int i = 1; i < STEP_LAT_P - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign sum_o = pipe[STEP_LAT_P-2][2*BW-1:BW];
    assign c_o   = pipe[STEP_LAT_P-2][BW-1:0];
  end

endmodule

// File: rtl/kahan_merge.sv
// Folds two (sum, compensation) pairs per beat into one running Kahan pair with a
// single time-shared kahan_step, emitting the pair and beat count at end of frame.
module kahan_merge
  import kahan_pkg::*;
#(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT_P   = 2,
  parameter int CNT_W_P      = 8,
  localparam int BIT_WIDTH_I = bit_width(EXP_WIDTH_I, MANT_WIDTH_I)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [BIT_WIDTH_I-1:0] sum_a_i,
  input  logic [BIT_WIDTH_I-1:0] c_a_i,
  input  logic [BIT_WIDTH_I-1:0] sum_b_i,
  input  logic [BIT_WIDTH_I-1:0] c_b_i,
  input  logic                   last_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [BIT_WIDTH_I-1:0] sum_o,
  output logic [BIT_WIDTH_I-1:0] c_o,
  output logic [CNT_W_P-1:0]     nbeats_o
);

  localparam int LAT_W = $clog2(STEP_LAT_P + 1);

  state_t                          state;
  logic [1:0]                      k;
  logic [LAT_W-1:0]                lat_cnt;
  logic [3:0][BIT_WIDTH_I-1:0]     ops_q;
  logic                            last_q;
  logic [BIT_WIDTH_I-1:0]          run_sum, run_c, step_sum, step_c, elem;
  logic [CNT_W_P-1:0]              nbeats;

  assign elem     = ops_q[k];
  assign sum_o    = run_sum;
  assign c_o      = run_c;
  assign nbeats_o = nbeats;

  kahan_step #(
    .EXP_WIDTH_I (EXP_WIDTH_I),
    .MANT_WIDTH_I(MANT_WIDTH_I),
    .STEP_LAT_P  (STEP_LAT_P)
  ) u_step (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .elem_i(elem),
    .sum_i (run_sum),
    .c_i   (run_c),
    .sum_o (step_sum),
    .c_o   (step_c)
  );

  // Compensation terms are stored pre-negated so every step is a plain Kahan add.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      k       <= '0;
      lat_cnt <= '0;
      ops_q   <= '0;
      last_q  <= 1'b0;
      run_sum <= '0;
      run_c   <= '0;
      nbeats  <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            ops_q <= {BIT_WIDTH_I'(flip_sign(64'(c_b_i), BIT_WIDTH_I)), sum_b_i,
                      BIT_WIDTH_I'(flip_sign(64'(c_a_i), BIT_WIDTH_I)), sum_a_i};
            last_q  <= last_i;
            k       <= '0;
            lat_cnt <= '0;
            ready_o <= 1'b0;
            state   <= STEP;
            if (nbeats != {CNT_W_P{1'b1}}) nbeats <= nbeats + CNT_W_P'(1);
          end
        end
        STEP: begin
          if (lat_cnt == LAT_W'(STEP_LAT_P - 1)) begin
            run_sum <= step_sum;
            run_c   <= step_c;
            lat_cnt <= '0;
            if (k != 2'd3) begin
              k <= k + 2'd1;
            end else if (last_q) begin
              valid_o <= 1'b1;
              state   <= OUT;
            end else begin
              ready_o <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        OUT: begin
          if (ready_i) begin
            run_sum <= '0;
            run_c   <= '0;
            nbeats  <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kahan_merge.sv
// Scoreboard bench for kahan_merge: a real-arithmetic E5M2 Kahan model queues the
// expected (sum, c, nbeats) for each frame and each scenario task checks the DUT.
module tb_kahan_merge;

  localparam int LAT = 2;

  typedef struct {
    logic [7:0] s;
    logic [7:0] c;
    logic [1:0] n;
  } exp_t;

  logic       clk, rst, valid_i, ready_o, last_i, valid_o, ready_i;
  logic [7:0] sum_a_i, c_a_i, sum_b_i, c_b_i, sum_o, c_o;
  logic [1:0] nbeats_o;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb_q[$];
  logic [7:0] model_sum = 8'h00, model_c = 8'h00;
  int   model_n = 0;

  kahan_merge #(
    .EXP_WIDTH_I (5),
    .MANT_WIDTH_I(2),
    .STEP_LAT_P  (LAT),
    .CNT_W_P     (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_a_i (sum_a_i),
    .c_a_i   (c_a_i),
    .sum_b_i (sum_b_i),
    .c_b_i   (c_b_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .c_o     (c_o),
    .nbeats_o(nbeats_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real to_real(input logic [7:0] v);
    real r;
    if (v[6:2] == 5'd0) r = real'(v[1:0]) * $pow(2.0, -16.0);
    else                r = real'(4 + int'(v[1:0])) * $pow(2.0, real'(int'(v[6:2]) - 17));
    return v[7] ? -r : r;
  endfunction

  function automatic logic [7:0] from_real(input real r);
    real a, q, n, fl;
    int  e, ri;
    logic [7:0] res;
    a = (r < 0.0) ? -r : r;
    if (a == 0.0) return 8'h00;
    e = -14;
    while (e < 16 && a >= $pow(2.0, real'(e + 1))) e++;
    q  = $pow(2.0, real'(e - 2));
    n  = a / q;
    fl = $floor(n);
    ri = int'(fl);
    if ((n - fl) > 0.5 || ((n - fl) == 0.5 && (ri % 2) == 1)) ri++;
    if (ri >= 8) begin ri = 4; e++; end
    if (e > 15)       res = 8'h7C;
    else if (ri >= 4) res = {1'b0, 5'(e + 15), 2'(ri - 4)};
    else              res = {1'b0, 5'd0, 2'(ri)};
    if (r < 0.0 && res != 8'h00) res[7] = 1'b1;
    return res;
  endfunction

  task automatic model_op(input logic [7:0] el);
    real s, c, y, t;
    s = to_real(model_sum);
    c = to_real(model_c);
    y = to_real(from_real(to_real(el) - c));
    t = to_real(from_real(s + y));
    model_c   = from_real(to_real(from_real(t - s)) - y);
    model_sum = from_real(t);
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] ca, input logic [7:0] b,
                           input logic [7:0] cb, input logic last, output time t_acc);
    int g = 0;
    exp_t e;
    t_acc = 0;
    while (!ready_o && g < 100) begin @(negedge clk); g++; end
    if (!ready_o) begin
      vectors++; errors++;
      $display("[TB] FAIL send_timeout: ready_o=%b required 1", ready_o);
      return;
    end
    sum_a_i = a; c_a_i = ca; sum_b_i = b; c_b_i = cb; last_i = last; valid_i = 1'b1;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0;
    model_op(a); model_op(ca ^ 8'h80); model_op(b); model_op(cb ^ 8'h80);
    if (model_n < 3) model_n++;
    if (last) begin
      e.s = model_sum; e.c = model_c; e.n = 2'(model_n);
      sb_q.push_back(e);
      model_sum = 8'h00; model_c = 8'h00; model_n = 0;
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!valid_o && g < 100) begin @(negedge clk); g++; end
    if (!valid_o) begin
      vectors++; errors++;
      $display("[TB] FAIL valid_timeout: valid_o=%b required 1", valid_o);
    end
  endtask

  task automatic pop_expected(output exp_t e);
    e.s = 8'hxx; e.c = 8'hxx; e.n = 2'bxx;
    if (sb_q.size() == 0) begin
      vectors++; errors++;
      $display("[TB] FAIL scoreboard_empty: queue size 0 required >0");
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic handshake();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", ready_o); end
    vectors++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
    vectors++; if (sum_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_sum: got %h want 00", sum_o); end
    vectors++; if (c_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_c: got %h want 00", c_o); end
    vectors++; if (nbeats_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_nbeats: got %0d want 0", nbeats_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    time t;
    exp_t e;
    send_beat(8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, t);
    repeat (4 * LAT - 1) @(negedge clk);
    vectors++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_early: valid_o=%b want 0", valid_o); end
    @(negedge clk);
    vectors++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: valid_o=%b want 1", valid_o); end
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n} || e.s !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL single_result: got %h/%h/%0d want %h/%h/%0d (sum 3c)", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  task automatic test_two_beats();
    time t;
    exp_t e;
    send_beat(8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, t);
    send_beat(8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, t);
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n}) begin
      errors++;
      $display("[TB] FAIL two_beats: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  task automatic test_compensation();
    time t;
    exp_t e;
    send_beat(8'h40, 8'hBC, 8'h00, 8'h00, 1'b1, t);
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n}) begin
      errors++;
      $display("[TB] FAIL compensation: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
    send_beat(8'h40, 8'h00, 8'h3C, 8'hBC, 1'b0, t);
    send_beat(8'hC0, 8'h00, 8'h3C, 8'h00, 1'b1, t);
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n}) begin
      errors++;
      $display("[TB] FAIL signed_mix: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    time t1, t2;
    exp_t e;
    send_beat(8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, t1);
    send_beat(8'h00, 8'h00, 8'h3C, 8'h00, 1'b1, t2);
    vectors++;
    if ((t2 - t1) != time'((4 * LAT + 1) * 10)) begin
      errors++;
      $display("[TB] FAIL throughput: accept gap %0t want %0d", t2 - t1, (4 * LAT + 1) * 10);
    end
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n}) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    time t;
    exp_t e;
    send_beat(8'h40, 8'h00, 8'h40, 8'h00, 1'b1, t);
    wait_valid();
    pop_expected(e);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({valid_o, ready_o, sum_o, c_o, nbeats_o} !== {1'b1, 1'b0, e.s, e.c, e.n}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v%b r%b %h/%h/%0d want v1 r0 %h/%h/%0d",
                 i, valid_o, ready_o, sum_o, c_o, nbeats_o, e.s, e.c, e.n);
      end
      sum_a_i = 8'h3C; last_i = 1'b1; valid_i = (i % 2) == 1;
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0;
    end
    handshake();
    vectors++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: got v%b r%b want v0 r1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid();
    time t;
    exp_t e;
    send_beat(8'h3C, 8'h00, 8'h3C, 8'h00, 1'b0, t);
    repeat (2 * LAT) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({ready_o, valid_o, sum_o, c_o, nbeats_o} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: got r%b v%b %h/%h/%0d want r1 v0 00/00/0",
               ready_o, valid_o, sum_o, c_o, nbeats_o);
    end
    model_sum = 8'h00; model_c = 8'h00; model_n = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(8'h00, 8'h00, 8'h3C, 8'h00, 1'b1, t);
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n} || nbeats_o !== 2'd1) begin
      errors++;
      $display("[TB] FAIL after_reset: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  task automatic test_saturation();
    time t;
    exp_t e;
    for (int i = 0; i < 5; i++) send_beat(8'h3C, 8'h00, 8'h00, 8'h00, i == 4, t);
    wait_valid();
    pop_expected(e);
    vectors++;
    if ({sum_o, c_o, nbeats_o} !== {e.s, e.c, e.n} || nbeats_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL saturation: got %h/%h/%0d want %h/%h/%0d", sum_o, c_o, nbeats_o, e.s, e.c, e.n);
    end
    handshake();
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; last_i = 1'b0;
    sum_a_i = 8'h00; c_a_i = 8'h00; sum_b_i = 8'h00; c_b_i = 8'h00;
    test_reset();
    test_single();
    test_two_beats();
    test_compensation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
